// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, line levels and baud divider constants.
// Used by the transmitter, the receiver and the baud-rate generator.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WAIT   = 3'd1;
    localparam state_t ST_START  = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_PARITY = 3'd4;
    localparam state_t ST_STOP   = 3'd5;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    localparam int CLK_HZ          = 50_000_000;
    localparam int BAUD_DIV_9600   = 5208;
    localparam int BAUD_DIV_19200  = 2604;
    localparam int BAUD_DIV_38400  = 1302;
    localparam int BAUD_DIV_57600  = 868;

    // clk cycles per bit for each baud-generator select code
    function automatic int baud_div(input logic [1:0] sel);
        case (sel)
            2'b00:   return BAUD_DIV_9600;
            2'b01:   return BAUD_DIV_19200;
            2'b10:   return BAUD_DIV_38400;
            default: return BAUD_DIV_57600;
        endcase
    endfunction

endpackage

// File: rtl/baud_tick_sync.sv
// Brings the asynchronous level baud clock into clk and turns its rising edge
// into a single-cycle baud_tick.
module baud_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic baud_clk,
    output logic baud_tick
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= baud_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign baud_tick = s2 & ~s3;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: ready/valid byte load, LSB-first framing with optional parity,
// one bit per baud_tick, registered glitch-free tx line.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | line high, tx_ready=1, waiting for a load
// WAIT      | byte captured, waiting for the tick that starts the frame
// START     | start bit on the line
// DATA      | data bits on the line, LSB first
// PARITY    | parity bit on the line
// STOP      | stop bit(s) on the line
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int                CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic              PAR_EN    = (PARITY_EN != 0);
    localparam logic              PAR_ODD   = (PARITY_ODD != 0);

    logic                 baud_tick;
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 parity_q;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 load;

    baud_tick_sync u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_clk  (baud_clk),
        .baud_tick (baud_tick)
    );

    assign load = tx_valid && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (load)      state_d = ST_WAIT;
            ST_WAIT:   if (baud_tick) state_d = ST_START;
            ST_START:  if (baud_tick) state_d = ST_DATA;
            ST_DATA:
                if (baud_tick && bit_cnt_q == LAST_BIT)
                    state_d = PAR_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (baud_tick) state_d = ST_STOP;
            ST_STOP:   if (baud_tick && stop_cnt_q == LAST_STOP) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Shift register and counters; terminal values are compared, never wrapped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            if (load) begin
                shreg_q  <= tx_data;
                parity_q <= (^tx_data) ^ PAR_ODD;
            end
            if (baud_tick) begin
                case (state_q)
                    ST_START: bit_cnt_q <= '0;
                    ST_DATA:
                        if (bit_cnt_q != LAST_BIT) begin
                            shreg_q   <= shreg_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    ST_STOP:  if (stop_cnt_q != LAST_STOP) stop_cnt_q <= 1'b1;
                    default:  ;
                endcase
            end
            if (state_q != ST_STOP) stop_cnt_q <= 1'b0;
        end
    end

    // Next line level is chosen from the current state so tx moves only on the tick edge.
    always_comb begin
        tx_d     = tx_q;
        done_d   = 1'b0;
        tx_ready = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
        if (state_q == ST_IDLE) begin
            tx_d = IDLE_LEVEL;
        end else if (baud_tick) begin
            case (state_q)
                ST_WAIT:   tx_d = START_LEVEL;
                ST_START:  tx_d = shreg_q[0];
                ST_DATA:
                    if (bit_cnt_q != LAST_BIT) tx_d = shreg_q[1];
                    else                       tx_d = PAR_EN ? parity_q : IDLE_LEVEL;
                ST_PARITY: tx_d = IDLE_LEVEL;
                ST_STOP: begin
                    tx_d   = IDLE_LEVEL;
                    done_d = (stop_cnt_q == LAST_STOP);
                end
                default:   tx_d = IDLE_LEVEL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q   <= IDLE_LEVEL;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            done_q <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, 8E2, 8O1 at 57600 baud and 8N1 at 9600 baud)
// driven from a table of frames plus back-to-back, busy-load and mid-frame reset sequences.
module tb_uart_tx;

    localparam int DIV_FAST = 868;
    localparam int DIV_SLOW = 5208;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic [11:0] frame;   // {stop(s), parity, data msb..lsb, start}
        int         nbits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_mid_n = 1'b1;
    logic       rst0_n;
    logic       baud_a = 1'b0;
    logic       baud_b = 1'b0;
    int         cnt_a = 0;
    int         cnt_b = 0;
    int         cyc = 0;

    logic [7:0] data_v [4];
    logic [3:0] valid_v = 4'b0;
    logic [3:0] ready_w, tx_w, busy_w, done_w;

    int         acc_cnt [4];
    int         done_cnt [4];
    int         last_fall [4];
    int         nvec = 0;
    int         nfail = 0;
    vec_t       vecs [6];

    assign rst0_n = rst_n & rst_mid_n;

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        cnt_a  <= (cnt_a == DIV_FAST - 1) ? 0 : cnt_a + 1;
        baud_a <= (cnt_a < DIV_FAST / 2);
        cnt_b  <= (cnt_b == DIV_SLOW - 1) ? 0 : cnt_b + 1;
        baud_b <= (cnt_b < DIV_SLOW / 2);
        for (int d = 0; d < 4; d++) begin
            if (valid_v[d] && ready_w[d]) acc_cnt[d] <= acc_cnt[d] + 1;
            if (done_w[d])                done_cnt[d] <= done_cnt[d] + 1;
        end
    end

    uart_tx u0 (
        .clk(clk), .rst_n(rst0_n), .baud_clk(baud_a), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_a), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_a), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2])
    );
    uart_tx u3 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_b), .tx_data(data_v[3]), .tx_valid(valid_v[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3])
    );

    function automatic int div_of(input int d);
        return (d == 3) ? DIV_SLOW : DIV_FAST;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        nvec++;
        if (act < lo || act > hi) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Present a byte with tx_valid and hold it until the cycle it is accepted.
    task automatic load(input int d, input logic [7:0] b, output int acc);
        acc = -1;
        @(negedge clk);
        data_v[d]  = b;
        valid_v[d] = 1'b1;
        for (int i = 0; i < 2 * div_of(d) + 40; i++) begin
            if (ready_w[d]) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) chk("load_timeout", 0, 1);
        else @(posedge clk);
        #1 valid_v[d] = 1'b0;
    endtask

    task automatic wait_fall(input int d, output int fall);
        fall = -1;
        for (int i = 0; i < 2 * div_of(d) + 40; i++) begin
            @(negedge clk);
            if (tx_w[d] == 1'b0) begin
                fall = cyc;
                break;
            end
        end
        if (fall < 0) chk("start_timeout", 0, 1);
        last_fall[d] = fall;
    endtask

    // Samples every bit mid-period and checks the tx_done position and width.
    task automatic check_frame(input int d, input string name, input logic [11:0] frame,
                               input int nb, output int done_at);
        int dv;
        int fall;
        int pulses;
        dv      = div_of(d);
        pulses  = 0;
        done_at = -1;
        wait_fall(d, fall);
        if (fall < 0) return;
        for (int cnt = 0; cnt <= nb * dv + 3; cnt++) begin
            if (cnt > 0) @(negedge clk);
            if (cnt % dv == dv / 2) begin
                chk($sformatf("%s bit%0d", name, cnt / dv), int'(tx_w[d]), int'(frame[cnt / dv]));
                if (cnt == dv / 2) chk($sformatf("%s busy", name), int'(busy_w[d]), 1);
            end
            if (done_w[d]) begin
                pulses++;
                if (done_at < 0) done_at = cyc;
            end
        end
        chk_range($sformatf("%s done_time", name), done_at - fall, nb * dv - 1, nb * dv + 1);
        chk($sformatf("%s done_pulses", name), pulses, 1);
    endtask

    task automatic run_table(input int d);
        int acc;
        int dn;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].dut == d) begin
                load(d, vecs[i].data, acc);
                check_frame(d, $sformatf("vec%0d", i), vecs[i].frame, vecs[i].nbits, dn);
                chk_range($sformatf("vec%0d latency", i), last_fall[d] - acc, 1, div_of(d) + 3);
                chk_range($sformatf("vec%0d done_seen", i), dn, 1, 1 << 30);
            end
        end
    endtask

    task automatic run_sequences;
        int acc;
        int base;
        int d1;
        int d2;
        int f2;
        int got;

        // Back-to-back with tx_valid held high: 0x55 then 0x0F.
        base = acc_cnt[0];
        fork
            begin
                got = 0;
                @(negedge clk);
                data_v[0]  = 8'h55;
                valid_v[0] = 1'b1;
                for (int i = 0; i < 25 * DIV_FAST && got < 2; i++) begin
                    if (ready_w[0]) begin
                        got++;
                        @(posedge clk);
                        #1 data_v[0] = 8'h0F;
                        if (got == 2) valid_v[0] = 1'b0;
                    end
                    @(negedge clk);
                end
                valid_v[0] = 1'b0;
                if (got < 2) chk("b2b_accept_timeout", got, 2);
            end
            begin
                check_frame(0, "b2b_55", 12'b00_1_01010101_0, 10, d1);
                check_frame(0, "b2b_0F", 12'b00_1_00001111_0, 10, d2);
                f2 = last_fall[0];
                chk("b2b_gap", f2 - d1, DIV_FAST);
                chk_range("b2b_second_done", d2 - f2, 10 * DIV_FAST - 1, 10 * DIV_FAST + 1);
            end
        join
        repeat (2) @(negedge clk);
        chk("b2b_accepts", acc_cnt[0] - base, 2);

        // Load attempt while busy is ignored.
        load(0, 8'hA5, acc);
        base = acc_cnt[0];
        fork
            check_frame(0, "busy_A5", 12'b00_1_10100101_0, 10, d1);
            begin
                repeat (3 * DIV_FAST) @(negedge clk);
                data_v[0]  = 8'hFF;
                valid_v[0] = 1'b1;
                chk("busy_ready0", int'(ready_w[0]), 0);
                @(negedge clk);
                chk("busy_ready1", int'(ready_w[0]), 0);
                valid_v[0] = 1'b0;
            end
        join
        chk("busy_ignored", acc_cnt[0] - base, 0);
        chk_range("busy_latency", last_fall[0] - acc, 1, DIV_FAST + 3);

        // Reset in the middle of data bit 3.
        load(0, 8'hA5, acc);
        wait_fall(0, f2);
        repeat (4 * DIV_FAST + DIV_FAST / 2) @(negedge clk);
        chk("rst_pre_tx", int'(tx_w[0]), 0);
        base = done_cnt[0];
        rst_mid_n = 1'b0;
        #1;
        chk("rst_tx", int'(tx_w[0]), 1);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_ready", int'(ready_w[0]), 1);
        repeat (10) @(negedge clk);
        rst_mid_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", done_cnt[0] - base, 0);
        load(0, 8'h3C, acc);
        check_frame(0, "post_rst_3C", 12'b00_1_00111100_0, 10, d1);
        chk_range("post_rst_latency", last_fall[0] - acc, 1, DIV_FAST + 3);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 4; d++) begin
            data_v[d]    = 8'h00;
            acc_cnt[d]   = 0;
            done_cnt[d]  = 0;
            last_fall[d] = -1;
        end
        vecs[0] = '{0, 8'hA5, 12'b00_1_10100101_0, 10};
        vecs[1] = '{1, 8'hA5, 12'b11_0_10100101_0, 12};
        vecs[2] = '{1, 8'h07, 12'b11_1_00000111_0, 12};
        vecs[3] = '{2, 8'hA5, 12'b0_1_1_10100101_0, 11};
        vecs[4] = '{2, 8'h01, 12'b0_1_0_00000001_0, 11};
        vecs[5] = '{3, 8'h00, 12'b00_1_00000000_0, 10};

        repeat (5) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset tx%0d", d), int'(tx_w[d]), 1);
            chk($sformatf("reset ready%0d", d), int'(ready_w[d]), 1);
            chk($sformatf("reset busy%0d", d), int'(busy_w[d]), 0);
            chk($sformatf("reset done%0d", d), int'(done_w[d]), 0);
        end
        rst_n = 1'b1;
        repeat (3 * DIV_FAST) @(negedge clk);
        chk("idle_no_done", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3], 0);
        chk("idle_tx", int'(tx_w), 4'hF);

        fork
            begin
                run_table(0);
                run_sequences();
            end
            run_table(1);
            run_table(2);
            run_table(3);
        join

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
